// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM state type and constants for muldiv_hilo
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam int ITERS = 32;

    localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add / restoring-divide step on a 64-bit accumulator
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] sum;
    logic [32:0] top;
    logic [32:0] diff;

    // Multiply: acc = {partial, multiplier}; add multiplicand when the low bit is set, shift right.
    // Divide:   acc = {remainder, dividend}; shift left, trial-subtract divisor, keep if no borrow.
    // The remainder is always below the divisor, so a borrow-free difference fits in 32 bits.
    always_comb begin
        sum     = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
        top     = acc_in[63:31];
        diff    = top - {1'b0, operand};
        acc_out = {sum, acc_in[31:1]};
        if (is_div) begin
            if (!diff[32]) begin
                acc_out = {diff[31:0], acc_in[30:0], 1'b1};
            end else begin
                acc_out = {top[31:0], acc_in[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative 32x32 multiply/divide unit with HI/LO result registers
module muldiv_hilo
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    localparam logic [5:0] LAST_STEP = 6'(ITERS - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] opnd;
    logic [1:0]  op_r;
    logic        neg_q;
    logic        neg_r;
    logic        b_zero;
    logic [31:0] a_raw;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        is_div_r;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes at acceptance; unsigned ops pass straight through
    always_comb begin
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        abs_a     = (in_signed && a[31]) ? (~a + 32'd1) : a;
        abs_b     = (in_signed && b[31]) ? (~b + 32'd1) : b;
    end

    // Sign correction of the finished magnitude result; the remainder follows the dividend
    always_comb begin
        is_div_r = (op_r == OP_DIV) || (op_r == OP_DIVU);
        prod_fix = neg_q ? (~acc + 64'd1) : acc;
        quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    muldiv_step u_step (
        .is_div  (is_div_r),
        .acc_in  (acc),
        .operand (opnd),
        .acc_out (acc_next)
    );

    // Control FSM, iteration counter and HI/LO update; registered busy/done/dbz
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            op_r   <= OP_MULT;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) begin
                        hi <= wr_data;
                    end
                    if (wr_lo) begin
                        lo <= wr_data;
                    end
                    if (start) begin
                        acc    <= {32'd0, abs_a};
                        opnd   <= abs_b;
                        op_r   <= op;
                        neg_q  <= in_signed && (a[31] ^ b[31]);
                        neg_r  <= in_signed && a[31];
                        b_zero <= (b == 32'd0);
                        a_raw  <= a;
                        cnt    <= 6'd0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_r) begin
                        if (b_zero) begin
                            hi  <= a_raw;
                            lo  <= DBZ_QUOT;
                            dbz <= 1'b1;
                        end else begin
                            hi  <= rem_fix;
                            lo  <= quot_fix;
                            dbz <= 1'b0;
                        end
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // mfhi/mflo read straight from the registers, no bypass of an in-flight result
    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - directed and random scoreboard bench for muldiv_hilo
module tb_muldiv_hilo;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        rd_sel = 1'b0;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        dbz;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    logic model_dbz = 1'b0;

    muldiv_hilo dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .dbz     (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic sel, output logic [31:0] v);
        rd_sel = sel;
        #1;
        v = rd_data;
    endtask

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dbz = d;
        return e;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic d);
        exp_t e;
        longint sx;
        longint sy;
        longint p;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dbz = d;
        case (o)
            OP_MULT: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else begin
                    p = sx / sy;
                    e.lo = p[31:0];
                    p = sx % sy;
                    e.hi = p[31:0];
                    e.dbz = 1'b0;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                    e.dbz = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge; the start pulse is taken at the following rising edge
    task automatic launch_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input exp_t e);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(e);
        model_dbz = e.dbz;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    // n0 = negedges seen since the accepting edge; done is due at the 34th
    task automatic finish_op(input string tag, input int n0);
        int n;
        logic [31:0] v;
        exp_t e;
        n = n0;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            read_reg(1'b1, v);
            check({tag, "_hi"}, 64'(v), 64'(e.hi));
            read_reg(1'b0, v);
            check({tag, "_lo"}, 64'(v), 64'(e.lo));
            check({tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_exp(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input exp_t e);
        launch_exp(o, x, y, e);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        finish_op(tag, 1);
    endtask

    task automatic run_model(input string tag, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y);
        run_exp(tag, o, x, y, model(o, x, y, model_dbz));
    endtask

    initial begin
        logic [31:0] v;
        int n;
        int extra;

        // reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        read_reg(1'b1, v);
        check("rst_hi", 64'(v), 64'd0);
        read_reg(1'b0, v);
        check("rst_lo", 64'(v), 64'd0);

        // first start accepted right after reset release
        @(negedge clk);
        rst_n = 1'b1;
        run_exp("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
        run_exp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
        run_exp("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
        run_exp("divu_7by2", OP_DIVU, 32'd7, 32'd2, mk(32'd1, 32'd3, 1'b0));
        run_exp("div_by_zero", OP_DIV, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 1'b1));
        run_model("mult_keeps_dbz", OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        run_exp("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0));

        // mthi/mtlo: both strobes together, then one alone
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b0; wr_data = 32'h1111_1111;
        @(negedge clk);
        wr_hi = 1'b0;
        read_reg(1'b1, v);
        check("mthi", 64'(v), 64'h1111_1111);
        read_reg(1'b0, v);
        check("mtlo_both", 64'(v), 64'hCAFE_F00D);

        // second start and write strobe while busy are dropped
        @(negedge clk);
        launch_exp(OP_MULT, 32'd3, 32'd4, mk(32'd0, 32'd12, 1'b0));
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        read_reg(1'b1, v);
        check("busy_read_pre_op", 64'(v), 64'h1111_1111);
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        wr_hi = 1'b1; wr_data = 32'h0000_AAAA;
        @(negedge clk);
        n++;
        start = 1'b0; wr_hi = 1'b0;
        read_reg(1'b1, v);
        check("busy_write_dropped", 64'(v), 64'h1111_1111);
        finish_op("mult_3x4_ignore", n);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        check("no_queued_op", 64'(extra), 64'd0);

        // strobe with an accepted start writes, then FIX overwrites
        wr_lo = 1'b1; wr_data = 32'h5555_5555;
        launch_exp(OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
        wr_lo = 1'b0;
        read_reg(1'b0, v);
        check("start_strobe_lo", 64'(v), 64'h5555_5555);
        finish_op("divu_100by7", 1);

        // reset mid-operation abandons it
        wr_lo = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        launch_exp(OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                read_reg(1'b0, v);
                check("busy_read_mtlo", 64'(v), 64'h0000_1234);
            end
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        read_reg(1'b1, v);
        check("midrst_hi", 64'(v), 64'd0);
        read_reg(1'b0, v);
        check("midrst_lo", 64'(v), 64'd0);
        sb.delete();
        model_dbz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("midrst_no_done", 64'(extra), 64'd0);
        read_reg(1'b0, v);
        check("midrst_lo_after", 64'(v), 64'd0);

        // random operations against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            logic [1:0] o;
            logic [31:0] x;
            logic [31:0] y;
            o = 2'(i % 4);
            x = $urandom;
            y = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i == 5) y = -y;
            @(negedge clk);
            run_model($sformatf("rand%0d", i), o, x, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  request a new operation; sampled in IDLE only
- op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- a  in  32  multiplicand / dividend
- b  in  32  multiplier / divisor
- wr_hi  in  1  mthi write strobe
- wr_lo  in  1  mtlo write strobe
- wr_data  in  32  mthi/mtlo data
- rd_sel  in  1  0 selects LO, 1 selects HI
- rd_data  out  32  combinational read of the selected register (mfhi/mflo)
- busy  out  1  operation in flight; the pipeline stalls on it
- done  out  1  one-cycle completion pulse
- dbz  out  1  last divide had a zero divisor

Function
REQ-003 HI/LO SHALL hold the 64-bit product as {HI,LO}, and for divides HI=remainder, LO=quotient.
REQ-004 The FSM SHALL have states IDLE, RUN, FIX.
- IDLE + start -> RUN: latch |a|, |b|, result signs, op; clear the 6-bit iteration counter.
- RUN: one radix-2 step per cycle (shift-add multiply or restoring divide); -> FIX after the 32nd step.
- FIX: apply sign correction, write HI/LO, update dbz, -> IDLE.
REQ-005 Latency: for start sampled at edge T, HI/LO SHALL update at edge T+33; done SHALL be high in exactly the cycle following T+33; busy SHALL be high from edge T through edge T+33, and low in the done cycle.
REQ-006 MULT SHALL compute the signed 64-bit product; MULTU SHALL compute the unsigned 64-bit product.
REQ-007 DIV quotient SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign; DIVU SHALL be unsigned.
REQ-008 Divide by zero SHALL give HI=a, LO=0xFFFFFFFF, dbz=1; any other completed divide SHALL clear dbz; multiplies SHALL leave dbz unchanged.
REQ-009 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no trap.
REQ-010 start while busy SHALL be ignored, and no queueing SHALL occur.
REQ-011 wr_hi/wr_lo in IDLE SHALL write wr_data at the edge; both strobes together SHALL write both registers.
- Strobes while busy SHALL be dropped.
- A strobe in the same cycle as an accepted start SHALL write, then be overwritten at FIX.
REQ-012 rd_data SHALL return the current register value with no bypass; during busy it returns the pre-operation value.
REQ-013 Operands a/b/op SHALL only be sampled at start acceptance; later changes SHALL have no effect.

Reset
REQ-014 rst_n low SHALL immediately force the following, regardless of state:
- HI=0, LO=0
- busy=0, done=0, dbz=0
- FSM in IDLE, counter 0
REQ-015 Reset mid-operation SHALL abandon the operation, with no partial HI/LO write.
REQ-016 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-017 The shared package muldiv_pkg SHALL hold the following, and nothing else:
- op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
- the state typedef
- the ITERS=32 constant
- the DBZ_QUOT=0xFFFFFFFF constant
REQ-018 The per-cycle datapath step (shift-add / restore-subtract on a 64-bit accumulator) SHALL be a sub-module named muldiv_step.
- It SHALL be purely combinational.
- The FSM, counter, sign fix and HI/LO SHALL stay in muldiv_hilo.

Verification
REQ-019 MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; done exactly 34 cycles after start was asserted, busy low in the done cycle.
REQ-020 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-021 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=2 -> LO=3, HI=1, dbz=0.
REQ-022 DIV a=5, b=0 -> HI=5, LO=0xFFFFFFFF, dbz=1; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, dbz=0.
REQ-023 Start MULT 3*4, pulse start again with 9*9 and wr_hi=0xAAAA in cycle 5 -> second start and write ignored, HI=0, LO=12.
REQ-024 wr_lo=0x1234 in IDLE, then start DIVU 100/7, then assert rst_n=0 in cycle 10 -> busy=0, HI=LO=0 immediately, no done pulse.
